// File: rtl/cmd_pkg.sv
// cmd_pkg: command bus codes and responder state encoding shared by generator and responder
package cmd_pkg;
  localparam logic [2:0] IDLE_C = 3'b111;
  localparam logic [2:0] PH1_C  = 3'b011;
  localparam logic [2:0] WR2_C  = 3'b101;
  localparam logic [2:0] RD2_C  = 3'b110;
  typedef enum logic [1:0] {IDLE, PH1, PH2W, PH2R} state_t;
endpackage

// File: rtl/cmd_sat_cnt.sv
// cmd_sat_cnt: saturating up counter with increment enable and async active-high clear
module cmd_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/cmd_responder.sv
// cmd_responder: decodes command bus into write/read strobes, flags violations, counts transactions
// CMD_ERR_CNT_EN adds a saturating err_cnt port.
module cmd_responder
  import cmd_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       cmd,
  output logic             wr_stb,
  output logic             rd_stb,
  output logic             err,
  output logic             busy,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [CNT_W-1:0] rd_cnt
`ifdef CMD_ERR_CNT_EN
  ,output logic [CNT_W-1:0] err_cnt
`endif
);
  state_t state, nxt;
  logic wr_n, rd_n, err_n;
  always_comb begin
    nxt   = state;
    wr_n  = 1'b0;
    rd_n  = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: begin
        nxt   = cmd == PH1_C ? PH1 : IDLE;
        err_n = cmd != PH1_C && cmd != IDLE_C;
      end
      PH1: begin
        wr_n  = cmd == WR2_C;
        rd_n  = cmd == RD2_C;
        err_n = !wr_n && !rd_n;
        nxt   = wr_n ? PH2W : rd_n ? PH2R : cmd == PH1_C ? PH1 : IDLE;
      end
      default: begin
        nxt   = cmd == PH1_C ? PH1 : IDLE;
        err_n = cmd != PH1_C && cmd != IDLE_C;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= IDLE;
      wr_stb <= 1'b0;
      rd_stb <= 1'b0;
      err    <= 1'b0;
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      state  <= nxt;
      wr_stb <= wr_n;
      rd_stb <= rd_n;
      err    <= err_n;
      wr_cnt <= wr_cnt + CNT_W'(wr_n);
      rd_cnt <= rd_cnt + CNT_W'(rd_n);
    end
  assign busy = state != IDLE;
`ifdef CMD_ERR_CNT_EN
  cmd_sat_cnt #(.W(CNT_W)) u_err_cnt (.clk(clk), .rst(rst), .inc(err_n), .cnt(err_cnt));
`endif
endmodule

// File: tb/tb_cmd_responder.sv
// tb_cmd_responder: directed vector table plus reset/wrap/saturation sequences for cmd_responder
module tb_cmd_responder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] cmd = 3'b111;
  logic       wr_stb, rd_stb, err, busy;
  logic [7:0] wr_cnt, rd_cnt;
`ifdef CMD_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif
  int n_cmp = 0;
  int n_fail = 0;

  cmd_responder #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cmd(cmd),
    .wr_stb(wr_stb), .rd_stb(rd_stb), .err(err), .busy(busy),
    .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
`ifdef CMD_ERR_CNT_EN
    ,.err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] c;
    logic [3:0] o;
    int wc;
    int rc;
    int ec;
  } vec_t;
  vec_t v[20];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input logic [2:0] c);
    cmd = c;
    @(posedge clk);
    #1;
  endtask

  function automatic int outs();
    return int'({wr_stb, rd_stb, err, busy});
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    cmd = 3'b111;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    v[0]  = '{3'b111, 4'b0000, 0, 0, 0};
    v[1]  = '{3'b011, 4'b0001, 0, 0, 0};
    v[2]  = '{3'b101, 4'b1001, 1, 0, 0};
    v[3]  = '{3'b111, 4'b0000, 1, 0, 0};
    v[4]  = '{3'b011, 4'b0001, 1, 0, 0};
    v[5]  = '{3'b110, 4'b0101, 1, 1, 0};
    v[6]  = '{3'b011, 4'b0001, 1, 1, 0};
    v[7]  = '{3'b101, 4'b1001, 2, 1, 0};
    v[8]  = '{3'b111, 4'b0000, 2, 1, 0};
    v[9]  = '{3'b110, 4'b0010, 2, 1, 1};
    v[10] = '{3'b011, 4'b0001, 2, 1, 1};
    v[11] = '{3'b111, 4'b0010, 2, 1, 2};
    v[12] = '{3'b010, 4'b0010, 2, 1, 3};
    v[13] = '{3'b011, 4'b0001, 2, 1, 3};
    v[14] = '{3'b011, 4'b0011, 2, 1, 4};
    v[15] = '{3'b110, 4'b0101, 2, 2, 4};
    v[16] = '{3'b101, 4'b0010, 2, 2, 5};
    v[17] = '{3'b011, 4'b0001, 2, 2, 5};
    v[18] = '{3'b101, 4'b1001, 3, 2, 5};
    v[19] = '{3'b000, 4'b0010, 3, 2, 6};

    @(posedge clk);
    #1;
    chk("reset_outs", outs(), 0);
    chk("reset_wr_cnt", int'(wr_cnt), 0);
    chk("reset_rd_cnt", int'(rd_cnt), 0);
`ifdef CMD_ERR_CNT_EN
    chk("reset_err_cnt", int'(err_cnt), 0);
`endif
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(3'b111);
      chk($sformatf("idle%0d_outs", i), outs(), 0);
    end

    for (int i = 0; i < 20; i++) begin
      tick(v[i].c);
      chk($sformatf("vec%0d_outs", i), outs(), int'(v[i].o));
      chk($sformatf("vec%0d_wr_cnt", i), int'(wr_cnt), v[i].wc);
      chk($sformatf("vec%0d_rd_cnt", i), int'(rd_cnt), v[i].rc);
`ifdef CMD_ERR_CNT_EN
      chk($sformatf("vec%0d_err_cnt", i), int'(err_cnt), v[i].ec);
`endif
    end

    do_reset();
    for (int i = 0; i < 256; i++) begin
      tick(3'b011);
      tick(3'b101);
      if (i == 254) chk("wr_cnt_255", int'(wr_cnt), 255);
    end
    chk("wr_cnt_wrap", int'(wr_cnt), 0);
    chk("wr_wrap_last_stb", outs(), 4'b1001);
    tick(3'b111);
    for (int i = 0; i < 300; i++) begin
      tick(3'b110);
      if (i == 0 || i == 299) chk($sformatf("viol%0d_outs", i), outs(), 4'b0010);
    end
`ifdef CMD_ERR_CNT_EN
    chk("err_cnt_sat", int'(err_cnt), 255);
`endif
    chk("viol_wr_cnt", int'(wr_cnt), 0);
    chk("viol_rd_cnt", int'(rd_cnt), 0);

    do_reset();
    tick(3'b011);
    tick(3'b101);
    tick(3'b011);
    chk("mid_busy_before", outs(), 4'b0001);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_outs", outs(), 0);
    chk("mid_rst_wr_cnt", int'(wr_cnt), 0);
    #1 rst = 1'b0;
    tick(3'b101);
    chk("post_rst_outs", outs(), 4'b0010);
    chk("post_rst_wr_cnt", int'(wr_cnt), 0);
    tick(3'b111);
    chk("post_rst_idle", outs(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
